// File: rtl/pim_seq_pkg.sv
// rtl/pim_seq_pkg.sv - shared FSM states, register offsets, STATUS bit positions and helpers for pim_seq_ctrl
package pim_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } pim_state_e;

    localparam logic [4:0] OFF_CMD    = 5'h00;
    localparam logic [4:0] OFF_ADDR   = 5'h04;
    localparam logic [4:0] OFF_DATA   = 5'h08;
    localparam logic [4:0] OFF_ZP     = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [4:0] OFF_RESULT = 5'h14;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_UNF     = 4;
    localparam int ST_CNT_LSB = 8;

    localparam logic [2:0] MODE_READ = 3'd3;
    localparam logic [2:0] MODE_MAC  = 3'd4;

    function automatic int popcount8(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // Signed a - b clamped to the int32 range; overflow shows as bit 32 disagreeing with bit 31.
    function automatic logic [31:0] sat_sub32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {a[31], a} - {b[31], b};
        if (d[32] != d[31]) return d[32] ? 32'h8000_0000 : 32'h7fff_ffff;
        return d[31:0];
    endfunction

endpackage

// File: rtl/pim_seq_ctrl_if.sv
// rtl/pim_seq_ctrl_if.sv - CPU register bus between the host and pim_seq_ctrl
interface pim_seq_ctrl_if;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic        wr_en_i;
    logic        rd_en_i;
    logic [31:0] data_o;

    modport master (output address_i, data_i, wr_en_i, rd_en_i, input data_o);
    modport slave  (input address_i, data_i, wr_en_i, rd_en_i, output data_o);
endinterface

// File: rtl/pim_result_fifo.sv
// rtl/pim_result_fifo.sv - show-ahead result FIFO, power-of-two depth, simultaneous push/pop
module pim_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pim_seq_ctrl.sv
// rtl/pim_seq_ctrl.sv - PIM macro sequencer: register window, enable sequencing, result capture into FIFO
// Optional build macro PIM_ZP_SUB_EN: results are stored as saturated (result - ZP).
module pim_seq_ctrl
    import pim_seq_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          IN_BEATS    = 16,
    parameter int          EXEC_CYCLES = 8,
    parameter int          OUT_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    pim_seq_ctrl_if.slave               cpu,
    output logic [NUM_CH-1:0]           pim_en_o,
    output logic [2:0]                  pim_mode_o,
    output logic [3:0]                  exec_cnt_o,
    output logic [6:0]                  row_addr7_o,
    output logic [8:0]                  col_addr9_o,
    output logic [31:0]                 in_word_o,
    output logic [$clog2(IN_BEATS)-1:0] in_word_idx_o,
    output logic                        in_buf_write_o,
    input  logic [32*NUM_CH-1:0]        result_i,
    input  logic                        result_valid_i,
    output logic                        busy_o
);
    localparam int IDX_W = $clog2(IN_BEATS);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W:0] BEATS_MAX = (IDX_W+1)'(IN_BEATS);

    pim_state_e        state, state_nxt;
    logic [2:0]        mode;
    logic [NUM_CH-1:0] ch_mask, pend, pend_nxt, new_mask;
    logic [3:0]        cnt;
    logic [IDX_W:0]    wcount;
    logic [31:0]       res_q [NUM_CH];
    logic [CH_W-1:0]   drain_idx;
    logic              done_st, err_st, ovf_st, unf_st;
    logic [31:0]       off, rd_data, status_word, push_data, zp_rd;
    logic              in_win, wr_cmd, wr_addr, wr_data, rd_status, rd_result;
    logic              start_req, start_ok, push, pop, fifo_empty;
    logic [31:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    assign off       = cpu.address_i - BASE_ADDR;
    assign in_win    = (off[31:5] == '0) && (off[1:0] == 2'b00);
    assign wr_cmd    = cpu.wr_en_i && in_win && (off[4:0] == OFF_CMD);
    assign wr_addr   = cpu.wr_en_i && in_win && (off[4:0] == OFF_ADDR);
    assign wr_data   = cpu.wr_en_i && in_win && (off[4:0] == OFF_DATA);
    assign rd_status = cpu.rd_en_i && in_win && (off[4:0] == OFF_STATUS);
    assign rd_result = cpu.rd_en_i && in_win && (off[4:0] == OFF_RESULT);
    assign pop       = rd_result && !fifo_empty;

    // A start must fit all selected channels into the FIFO before any enable is raised.
    assign new_mask  = cpu.data_i[8 +: NUM_CH];
    assign start_req = wr_cmd && cpu.data_i[31];
    assign start_ok  = start_req && (state == S_IDLE) && (new_mask != '0) &&
                       (popcount8(8'(new_mask)) <= OUT_DEPTH - int'(fifo_count));

    assign busy_o     = (state != S_IDLE);
    assign pim_en_o   = (state == S_EXEC) ? ch_mask : '0;
    assign exec_cnt_o = (state == S_EXEC) ? cnt : 4'd0;
    assign pim_mode_o = mode;

`ifdef PIM_ZP_SUB_EN
    logic [31:0] zp;
    always_ff @(posedge clk_i) begin
        if (rst_i)                                              zp <= '0;
        else if (cpu.wr_en_i && in_win && off[4:0] == OFF_ZP)   zp <= cpu.data_i;
    end
    assign zp_rd     = zp;
    assign push_data = sat_sub32(res_q[drain_idx], zp);
`else
    assign zp_rd     = '0;
    assign push_data = res_q[drain_idx];
`endif

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        push      = 1'b0;
        drain_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) drain_idx = CH_W'(i);
        end
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_EXEC;
            S_EXEC:  if (cnt == 4'(EXEC_CYCLES - 1))
                         state_nxt = (mode == MODE_READ || mode == MODE_MAC) ? S_WAIT : S_DONE;
            S_WAIT:  if (result_valid_i) begin
                         state_nxt = S_DRAIN;
                         pend_nxt  = ch_mask;
                     end
            S_DRAIN: begin
                         // Lowest pending channel goes out this cycle, then its bit is cleared.
                         push     = 1'b1;
                         pend_nxt = pend & (pend - NUM_CH'(1));
                         if (pend_nxt == '0) state_nxt = S_DONE;
                     end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        status_word                   = '0;
        status_word[ST_BUSY]          = busy_o;
        status_word[ST_DONE]          = done_st;
        status_word[ST_ERR]           = err_st;
        status_word[ST_OVF]           = ovf_st;
        status_word[ST_UNF]           = unf_st;
        status_word[ST_CNT_LSB +: 8]  = 8'(fifo_count);
        rd_data = '0;
        if (in_win) begin
            case (off[4:0])
                OFF_CMD:    begin
                                rd_data[2:0]        = mode;
                                rd_data[8 +: NUM_CH] = ch_mask;
                            end
                OFF_ADDR:   begin
                                rd_data[6:0]   = row_addr7_o;
                                rd_data[24:16] = col_addr9_o;
                            end
                OFF_ZP:     rd_data = zp_rd;
                OFF_STATUS: rd_data = status_word;
                OFF_RESULT: if (!fifo_empty) rd_data = fifo_head;
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            pend           <= '0;
            cnt            <= '0;
            mode           <= '0;
            ch_mask        <= '0;
            row_addr7_o    <= '0;
            col_addr9_o    <= '0;
            in_word_o      <= '0;
            in_word_idx_o  <= '0;
            in_buf_write_o <= 1'b0;
            wcount         <= '0;
            done_st        <= 1'b0;
            err_st         <= 1'b0;
            ovf_st         <= 1'b0;
            unf_st         <= 1'b0;
            cpu.data_o     <= '0;
            for (int c = 0; c < NUM_CH; c++) res_q[c] <= '0;
        end else begin
            state          <= state_nxt;
            pend           <= pend_nxt;
            cnt            <= (state == S_EXEC) ? cnt + 4'd1 : 4'd0;
            in_buf_write_o <= 1'b0;
            // Clear-on-read first so an event in the same cycle still sets its sticky bit.
            if (rd_status) begin
                done_st <= 1'b0;
                err_st  <= 1'b0;
                ovf_st  <= 1'b0;
                unf_st  <= 1'b0;
            end
            if (wr_cmd && state == S_IDLE) begin
                mode    <= cpu.data_i[2:0];
                ch_mask <= new_mask;
            end
            if (start_req && !start_ok) err_st <= 1'b1;
            if (wr_addr && state == S_IDLE) begin
                row_addr7_o <= cpu.data_i[6:0];
                col_addr9_o <= cpu.data_i[24:16];
            end
            if (wr_data && state == S_IDLE) begin
                if (wcount != BEATS_MAX) begin
                    in_word_o      <= cpu.data_i;
                    in_word_idx_o  <= wcount[IDX_W-1:0];
                    in_buf_write_o <= 1'b1;
                    wcount         <= wcount + (IDX_W+1)'(1);
                end else begin
                    ovf_st <= 1'b1;
                end
            end
            if (rd_result && fifo_empty) unf_st <= 1'b1;
            if (state == S_WAIT && result_valid_i) begin
                for (int c = 0; c < NUM_CH; c++) res_q[c] <= result_i[32*c +: 32];
            end
            if (state == S_DONE) begin
                wcount  <= '0;
                done_st <= 1'b1;
            end
            if (cpu.rd_en_i) cpu.data_o <= rd_data;
        end
    end

    pim_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );
endmodule
